// File: rtl/tachometer_rpm.sv
// Tachometer front end: synchronises and debounces a raw hall/encoder pulse, counts
// accepted rising edges over a fixed gate window and scales the count to RPM for the
// tach PID loop feedback port.
module tachometer_rpm #(
  parameter int unsigned CLK_FREQ_HZ     = 125_000_000,
  parameter int unsigned WINDOW_CYCLES   = 12_500_000,
  parameter int unsigned PULSES_PER_REV  = 600,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RPM_RESOLUTION  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      tach_in,
  output logic [RPM_RESOLUTION-1:0] rpm,
  output logic                      rpm_valid,
  output logic                      rpm_sat
);

  // 60 * 125 MHz overflows 32 bits, so the scale is worked out in 64 bits.
  localparam longint unsigned ScaleNum  = 64'(60) * 64'(CLK_FREQ_HZ);
  localparam longint unsigned ScaleDen  = 64'(WINDOW_CYCLES) * 64'(PULSES_PER_REV);
  localparam longint unsigned RPM_SCALE = (ScaleDen == 0) ? 64'd0 : ScaleNum / ScaleDen;
  localparam longint unsigned ScaleRem  = (ScaleDen == 0) ? 64'd1 : ScaleNum % ScaleDen;

  // Edge count and timer share one width: the count must be able to hold WINDOW_CYCLES.
  localparam int unsigned CntW   = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES + 1) : 1;
  localparam int unsigned ScaleW = (RPM_SCALE > 1) ? $clog2(RPM_SCALE + 1) : 1;
  localparam int unsigned ProdW  = CntW + ScaleW;
  // Compare width keeps the full product and at least one bit above full scale.
  localparam int unsigned CmpW   = (ProdW > RPM_RESOLUTION) ? ProdW : RPM_RESOLUTION + 1;
  localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CmpW-1:0] ScaleVec  = CmpW'(RPM_SCALE);
  localparam logic [CmpW-1:0] FullScale = CmpW'({RPM_RESOLUTION{1'b1}});
  localparam logic [CntW-1:0] LastTick  = CntW'(WINDOW_CYCLES - 1);
  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

  if ((ScaleDen == 0) || (ScaleRem != 0) || (RPM_SCALE < 1)) begin : g_bad_scale
    $error("tachometer_rpm: 60*CLK_FREQ_HZ must divide exactly by WINDOW_CYCLES*PULSES_PER_REV");
  end

  typedef enum logic [1:0] {
    StIdle,
    StFirst,
    StRun
  } state_e;

  state_e                state_q;
  logic                  sync1_q;
  logic                  sync2_q;
  logic                  filt_q;
  logic [DbW-1:0]        db_cnt_q;
  logic                  edge_q;
  logic [CntW-1:0]       timer_q;
  logic [CntW-1:0]       count_q;

  logic [CntW-1:0]       count_inc;
  logic [CmpW-1:0]       product;
  logic                  prod_sat;
  logic [RPM_RESOLUTION-1:0] rpm_next;

  // Synchroniser and debounce filter; runs regardless of en so re-enable sees no false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
      edge_q   <= 1'b0;
    end else begin
      sync1_q <= tach_in;
      sync2_q <= sync1_q;
      edge_q  <= 1'b0;
      if (sync2_q != filt_q) begin
        // Accept the new level only after DEBOUNCE_CYCLES disagreeing samples in a row.
        if (db_cnt_q == DbLast) begin
          filt_q   <= sync2_q;
          db_cnt_q <= '0;
          edge_q   <= sync2_q;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Saturating count including this cycle's edge, and full-width scaled speed.
  always_comb begin
    count_inc = count_q;
    if (edge_q && (count_q != {CntW{1'b1}})) begin
      count_inc = count_q + 1'b1;
    end
    product  = CmpW'(count_inc) * ScaleVec;
    prod_sat = (product > FullScale);
    rpm_next = prod_sat ? {RPM_RESOLUTION{1'b1}} : product[RPM_RESOLUTION-1:0];
  end

  // Gate-window FSM with registered rpm, rpm_sat and rpm_valid outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      count_q   <= '0;
      rpm       <= '0;
      rpm_sat   <= 1'b0;
      rpm_valid <= 1'b0;
    end else begin
      rpm_valid <= 1'b0;
      if (!en) begin
        // Disabling discards the partial window and clears the reported speed.
        state_q <= StIdle;
        timer_q <= '0;
        count_q <= '0;
        rpm     <= '0;
        rpm_sat <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StFirst;
            timer_q <= '0;
            count_q <= '0;
          end
          StFirst, StRun: begin
            if (timer_q == LastTick) begin
              // Window end: publish and restart without losing a gate cycle.
              state_q   <= StRun;
              timer_q   <= '0;
              count_q   <= '0;
              rpm       <= rpm_next;
              rpm_sat   <= prod_sat;
              rpm_valid <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
              count_q <= count_inc;
            end
          end
          default: begin
            state_q <= StIdle;
            timer_q <= '0;
            count_q <= '0;
          end
        endcase
      end
    end
  end

endmodule
